// File: rtl/bus_pkg.sv
// Shared encodings for the core-to-AHB initiator: access sizes, FSM states, alignment rule.
package bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } state_t;

    // An access is rejected if it straddles its natural boundary or uses the reserved size code.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian lane handling: extracts and extends a load lane, and merges store data into a word.
module load_align
    import bus_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] mask;

    always_comb begin
        sh     = {addr_lo_i, 3'b000};
        lane   = word_i >> sh;
        load_o = '0;
        mask   = '0;
        case (size_i)
            SZ_BYTE: begin
                load_o = {{24{~unsigned_i & lane[7]}}, lane[7:0]};
                mask   = 32'h0000_00FF;
            end
            SZ_HALF: begin
                load_o = {{16{~unsigned_i & lane[15]}}, lane[15:0]};
                mask   = 32'h0000_FFFF;
            end
            SZ_WORD: begin
                load_o = word_i;
                mask   = 32'hFFFF_FFFF;
            end
            default: ;
        endcase
        // Reserved size gives a zero mask, so the word passes through untouched.
        merge_o = (word_i & ~(mask << sh)) | ((wdata_i & mask) << sh);
    end

endmodule

// File: rtl/ahb_initiator.sv
// Single-outstanding core-to-RAM initiator: aligned loads, word stores and read-modify-write sub-word stores.
// Bus signals are registered and idle at zero outside bus states; one resp_valid pulse per accepted request.
module ahb_initiator
    import bus_pkg::*;
#(
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned WR_HOLD = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WR_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       addr_lo_q;
    logic [1:0]       size_q;
    logic             we_q;
    logic             uns_q;
    logic [31:0]      wdata_q;
    logic [31:0]      haddr_q;
    logic             hwrite_q;
    logic [31:0]      hwdata_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic [31:0]      resp_rdata_q;
    logic             resp_err_q;

    logic [31:0]      align_load;
    logic [31:0]      align_merge;

    // The aligner looks at HRDATA directly so the capture edge can register the final value.
    load_align u_align (
        .word_i     (HRDATA),
        .addr_lo_i  (addr_lo_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .load_o     (align_load),
        .merge_o    (align_merge)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_lo_q    <= '0;
            size_q       <= SZ_BYTE;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            haddr_q      <= '0;
            hwrite_q     <= 1'b0;
            hwdata_q     <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_lo_q   <= req_addr[1:0];
                        size_q      <= req_size;
                        we_q        <= req_we;
                        uns_q       <= req_unsigned;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (misaligned(req_size, req_addr[1:0])) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            haddr_q <= {req_addr[31:2], 2'b00};
                            if (!req_we) begin
                                state_q <= ST_RD;
                                cnt_q   <= RD_INIT;
                            end else if (req_size == SZ_WORD) begin
                                state_q  <= ST_WR;
                                cnt_q    <= WR_INIT;
                                hwrite_q <= 1'b1;
                                hwdata_q <= req_wdata;
                            end else begin
                                state_q <= ST_RMW_RD;
                                cnt_q   <= RD_INIT;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (cnt_q == '0) begin
                        state_q      <= ST_RESP;
                        haddr_q      <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= we_q ? '0 : align_load;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_RMW_RD: begin
                    if (cnt_q == '0) begin
                        state_q  <= ST_RMW_WR;
                        cnt_q    <= WR_INIT;
                        hwrite_q <= 1'b1;
                        hwdata_q <= align_merge;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_WR, ST_RMW_WR: begin
                    if (cnt_q == '0) begin
                        state_q      <= ST_RESP;
                        haddr_q      <= '0;
                        hwrite_q     <= 1'b0;
                        hwdata_q     <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign HADDR      = haddr_q;
    assign HWRITE     = hwrite_q;
    assign HWDATA     = hwdata_q;

endmodule

// File: tb/tb_ahb_initiator.sv
// Bench for ahb_initiator: directed scenarios plus random traffic against a byte-lane memory model.
module tb_ahb_initiator;

    localparam int RD_LAT  = 1;
    localparam int WR_HOLD = 2;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];
    logic        init_we;
    logic [7:0]  init_idx;
    logic [31:0] init_val;

    int n_chk;
    int n_bad;

    ahb_initiator #(.RD_LAT(RD_LAT), .WR_HOLD(WR_HOLD)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .HADDR        (HADDR),
        .HWRITE       (HWRITE),
        .HWDATA       (HWDATA),
        .HRDATA       (HRDATA)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Zero-wait RAM responder: combinational read, write on every edge HWRITE is high.
    assign HRDATA = ram[HADDR[9:2]];
    always @(posedge CLK) begin
        if (init_we)
            ram[init_idx] <= init_val;
        else if (HWRITE)
            ram[HADDR[9:2]] <= HWDATA;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: memory seen as four bytes; a request touches 1<<size bytes starting at addr[1:0].
    function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd, output logic [31:0] wr_word);
        logic [7:0] bt [4];
        int idx, b, nb;
        idx = int'(addr[9:2]);
        b   = int'(addr[1:0]);
        nb  = 1 << sz;
        rd = '0;
        wr_word = '0;
        err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
        if (err) return;
        for (int i = 0; i < 4; i++) bt[i] = ref_mem[idx][8*i +: 8];
        if (!we) begin
            for (int i = 0; i < nb; i++) rd[8*i +: 8] = bt[b+i];
            if (nb < 4 && !uns && bt[b+nb-1][7])
                for (int i = nb; i < 4; i++) rd[8*i +: 8] = 8'hFF;
        end else begin
            for (int i = 0; i < nb; i++) bt[b+i] = wd[8*i +: 8];
            for (int i = 0; i < 4; i++) wr_word[8*i +: 8] = bt[i];
            ref_mem[idx] = wr_word;
        end
    endfunction

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!req_ready && k < 32) begin
            @(negedge CLK);
            k++;
        end
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
    endtask

    task automatic run_xact(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd);
        logic        exp_err;
        logic [31:0] exp_rd, exp_wr, exp_haddr, last_wd;
        int          exp_lat, exp_nwr, lat, nwr;
        bit          haddr_ok, got;
        model(we, sz, uns, addr, wd, exp_err, exp_rd, exp_wr);
        if (exp_err)              exp_lat = 1;
        else if (!we)             exp_lat = RD_LAT + 1;
        else if (sz == 2'd2)      exp_lat = WR_HOLD + 1;
        else                      exp_lat = RD_LAT + WR_HOLD + 1;
        exp_nwr   = (we && !exp_err) ? WR_HOLD : 0;
        exp_haddr = exp_err ? 32'd0 : {addr[31:2], 2'b00};
        @(negedge CLK);
        drive(we, sz, uns, addr, wd);
        wait_ready(tag);
        @(negedge CLK);
        req_valid = 1'b0;
        lat = 1; nwr = 0; haddr_ok = 1; got = 0; last_wd = '0;
        for (int k = 0; k < 64; k++) begin
            if (resp_valid) begin
                got = 1;
                if (HADDR != 32'd0 || HWRITE) haddr_ok = 0;
                break;
            end
            if (HADDR != exp_haddr) haddr_ok = 0;
            if (HWRITE) begin
                nwr++;
                last_wd = HWDATA;
            end
            lat++;
            @(negedge CLK);
        end
        chk({tag, ".resp"},  {31'd0, got}, 32'd1);
        chk({tag, ".lat"},   lat, exp_lat);
        chk({tag, ".err"},   {31'd0, resp_err}, {31'd0, exp_err});
        chk({tag, ".rdata"}, resp_rdata, exp_rd);
        chk({tag, ".haddr"}, {31'd0, haddr_ok}, 32'd1);
        chk({tag, ".nwr"},   nwr, exp_nwr);
        if (exp_nwr != 0) chk({tag, ".hwdata"}, last_wd, exp_wr);
        @(negedge CLK);
        chk({tag, ".pulse"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, ".hold"},  resp_rdata, exp_rd);
    endtask

    initial begin
        logic        e;
        logic [31:0] r, w;
        int          k, lat;
        bit          seen;
        n_chk = 0;
        n_bad = 0;
        RST = 1'b1;
        req_valid = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        req_valid = 1'b0;
        init_we = 1'b0; init_idx = '0; init_val = '0;

        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            init_we  = 1'b1;
            init_idx = 8'(i);
            init_val = (i == 4) ? 32'hDEAD_BEEF : $urandom;
            ref_mem[i] = init_val;
        end
        @(negedge CLK);
        init_we = 1'b0;
        chk("rst.ready",  {31'd0, req_ready}, 32'd1);
        chk("rst.rvalid", {31'd0, resp_valid}, 32'd0);
        chk("rst.rdata",  resp_rdata, 32'd0);
        chk("rst.err",    {31'd0, resp_err}, 32'd0);
        chk("rst.bus",    HADDR | HWDATA | {31'd0, HWRITE}, 32'd0);
        RST = 1'b0;

        run_xact("ldw",   1'b0, 2'd2, 1'b0, 32'h0002_0010, 32'd0);
        chk("ldw.value", resp_rdata, 32'hDEAD_BEEF);
        run_xact("ldbs",  1'b0, 2'd0, 1'b0, 32'h0002_0013, 32'd0);
        chk("ldbs.value", resp_rdata, 32'hFFFF_FFDE);
        run_xact("ldbu",  1'b0, 2'd0, 1'b1, 32'h0002_0013, 32'd0);
        chk("ldbu.value", resp_rdata, 32'h0000_00DE);
        run_xact("stb",   1'b1, 2'd0, 1'b0, 32'h0002_0011, 32'h0000_0055);
        run_xact("ldw2",  1'b0, 2'd2, 1'b0, 32'h0002_0010, 32'd0);
        chk("ldw2.value", resp_rdata, 32'hDEAD_55EF);
        run_xact("misal", 1'b0, 2'd2, 1'b0, 32'h0002_0012, 32'd0);
        chk("misal.value", {31'd0, resp_err}, 32'd1);

        // Reset lands in the first RMW write cycle; that edge still writes one beat.
        @(negedge CLK);
        drive(1'b1, 2'd0, 1'b0, 32'h0002_0045, 32'h0000_00A7);
        wait_ready("rmwrst");
        @(negedge CLK);
        req_valid = 1'b0;
        k = 0;
        while (!HWRITE && k < 16) begin
            @(negedge CLK);
            k++;
        end
        chk("rmwrst.hw_seen", {31'd0, HWRITE}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rmwrst.hwrite", {31'd0, HWRITE}, 32'd0);
        chk("rmwrst.ready",  {31'd0, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) seen = 1;
            @(negedge CLK);
        end
        chk("rmwrst.noresp", {31'd0, seen}, 32'd0);
        model(1'b1, 2'd0, 1'b0, 32'h0002_0045, 32'h0000_00A7, e, r, w);
        run_xact("rmwrst.chk", 1'b0, 2'd2, 1'b0, 32'h0002_0044, 32'd0);

        // Reset wins over a request presented on the same edge.
        @(negedge CLK);
        drive(1'b0, 2'd2, 1'b0, 32'h0002_0010, 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        req_valid = 1'b0;
        chk("rstpri.haddr", HADDR, 32'd0);
        chk("rstpri.ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) seen = 1;
            @(negedge CLK);
        end
        chk("rstpri.noresp", {31'd0, seen}, 32'd0);

        // Back-to-back word stores with req_valid held high throughout.
        @(negedge CLK);
        drive(1'b1, 2'd2, 1'b0, 32'h0002_0020, 32'h1122_3344);
        wait_ready("b2b.a");
        @(negedge CLK);
        k = 0;
        while (!resp_valid && k < 32) begin
            @(negedge CLK);
            k++;
        end
        chk("b2b.a.resp",     {31'd0, resp_valid}, 32'd1);
        chk("b2b.a.notready", {31'd0, req_ready}, 32'd0);
        drive(1'b1, 2'd2, 1'b0, 32'h0002_0024, 32'hA5A5_5A5A);
        @(negedge CLK);
        chk("b2b.ready", {31'd0, req_ready}, 32'd1);
        @(negedge CLK);
        chk("b2b.accepted", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        lat = 1;
        k = 0;
        while (!resp_valid && k < 32) begin
            @(negedge CLK);
            lat++;
            k++;
        end
        chk("b2b.b.lat", lat, WR_HOLD + 1);
        model(1'b1, 2'd2, 1'b0, 32'h0002_0020, 32'h1122_3344, e, r, w);
        model(1'b1, 2'd2, 1'b0, 32'h0002_0024, 32'hA5A5_5A5A, e, r, w);
        run_xact("b2b.lda", 1'b0, 2'd2, 1'b0, 32'h0002_0020, 32'd0);
        run_xact("b2b.ldb", 1'b0, 2'd2, 1'b0, 32'h0002_0024, 32'd0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = 32'h0002_0000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
            run_xact("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
